// File: rtl/aemb_pkg.sv
// Shared definitions for the AEMB multi-thread register file slice.
//   MX_*  : write-back source select codes (rMXDST)
//   SZ_*  : store size codes (rOPC); code 3 is illegal and stores zero
//   state_e : register-file clear sequencer states
package aemb_pkg;

  localparam logic [1:0] MX_RES = 2'd0;  // ALU result
  localparam logic [1:0] MX_LNK = 2'd1;  // link PC
  localparam logic [1:0] MX_LDM = 2'd2;  // sized load data
  localparam logic [1:0] MX_NOP = 2'd3;  // no write-back

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/aemb_ldsz.sv
// Load sizer: picks the byte lanes flagged in sel out of dat and
// right-justifies them, zero- or sign-extending the upper bits.
// Ports:
//   sel  in  DW/8  byte-lane select (one-hot byte, aligned half, all ones)
//   sext in  1     sign-extend sub-word results
//   dat  in  DW    raw bus data
//   q    out DW    sized data; any unsupported select yields 0
module aemb_ldsz #(
  parameter int DW = 32
) (
  input  logic [DW/8-1:0] sel,
  input  logic            sext,
  input  logic [DW-1:0]   dat,
  output logic [DW-1:0]   q
);

  localparam int NB = DW / 8;

  int   nbits;  // width of the selected field, 0 when nothing matched
  logic top;    // MSB of the selected field

  always_comb begin
    q     = '0;
    nbits = 0;
    top   = 1'b0;
    if (sel == '1) begin
      q     = dat;
      nbits = DW;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (sel == (NB'(1) << k)) begin
          q     = DW'(dat[8*k +: 8]);
          top   = dat[8*k + 7];
          nbits = 8;
        end
      end
      for (int j = 0; j < NB / 2; j++) begin
        if (sel == (NB'(3) << (2 * j))) begin
          q     = DW'(dat[16*j +: 16]);
          top   = dat[16*j + 15];
          nbits = 16;
        end
      end
    end
    if (sext && nbits != 0 && nbits < DW) begin
      for (int i = 0; i < DW; i++) begin
        if (i >= nbits) q[i] = top;
      end
    end
  end

endmodule

// File: rtl/aemb_regf_mt.sv
// Multi-thread AEMB register file with load/store sizers.
// Three LUT-RAM copies (A, B, D) indexed by {thread, reg}; a clear
// sequencer zeroes every entry after reset before the pipeline may run.
// Ports:
//   gclk, grst        clock, synchronous active-high reset
//   gena              pipeline enable (freezes writes and dwb_dat_o)
//   rTHR, rTHW        read / write thread ids
//   rRA, rRB, rRD     read addresses (A, B operand, store source)
//   rRW, rMXDST       write-back address and source select
//   rPCLNK, rRESULT   link PC (word address) and ALU result
//   rOPC              store size
//   rDWBSEL, rSEXT    load lane select and sign-extend
//   dwb_dat_i         load data in
//   rREGA, rREGB      asynchronous operand reads
//   rDWBDI            sized load data (combinational)
//   dwb_dat_o         registered, sized store data
//   clr_busy          clear sequence running; pipeline must stall
//   state             current sequencer state, for observation
//
// Handshake: there is none; the block is a pipeline stage qualified only
// by gena. Callers hold gena low (stall) while clr_busy is high.
module aemb_regf_mt
  import aemb_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int THW = 1
) (
  input  logic              gclk,
  input  logic              grst,
  input  logic              gena,
  input  logic [THW-1:0]    rTHR,
  input  logic [THW-1:0]    rTHW,
  input  logic [AW-1:0]     rRA,
  input  logic [AW-1:0]     rRB,
  input  logic [AW-1:0]     rRD,
  input  logic [AW-1:0]     rRW,
  input  logic [1:0]        rMXDST,
  input  logic [DW-3:0]     rPCLNK,
  input  logic [DW-1:0]     rRESULT,
  input  logic [1:0]        rOPC,
  input  logic [DW/8-1:0]   rDWBSEL,
  input  logic              rSEXT,
  input  logic [DW-1:0]     dwb_dat_i,
  output logic [DW-1:0]     rREGA,
  output logic [DW-1:0]     rREGB,
  output logic [DW-1:0]     rDWBDI,
  output logic [DW-1:0]     dwb_dat_o,
  output logic              clr_busy,
  output state_e            state
);

  localparam int IW   = THW + AW;
  localparam int NREG = 2 ** IW;

  logic [DW-1:0] mem_a [NREG];
  logic [DW-1:0] mem_b [NREG];
  logic [DW-1:0] mem_d [NREG];

  state_e        state_nxt;
  logic [IW-1:0] clr_cnt;
  logic          run_we;
  logic          mem_we;
  logic [IW-1:0] mem_idx;
  logic [DW-1:0] mem_dat;
  logic [DW-1:0] wr_dat;
  logic [DW-1:0] reg_d;
  logic [DW-1:0] st_src;
  logic [DW-1:0] st_dat;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge gclk) begin
    if (grst) state <= ST_CLR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLR:  if (clr_cnt == '1) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_CLR;
    endcase
  end

  // Clear writes override the normal port; R0 is never a write target
  // in RUN so it keeps the zero put there by the sequencer.
  always_comb begin
    clr_busy = (state == ST_CLR);
    run_we   = (state == ST_RUN) && !grst && gena &&
               (rRW != '0) && (rMXDST != MX_NOP);
    mem_we   = clr_busy || run_we;
    mem_idx  = clr_busy ? clr_cnt : {rTHW, rRW};
    mem_dat  = clr_busy ? '0 : wr_dat;
  end

  always_ff @(posedge gclk) begin
    if (grst)                  clr_cnt <= '0;
    else if (state == ST_CLR)  clr_cnt <= clr_cnt + 1'b1;
  end

  // ------------------------------------------------------------ storage
  always_ff @(posedge gclk) begin
    if (mem_we) begin
      mem_a[mem_idx] <= mem_dat;
      mem_b[mem_idx] <= mem_dat;
      mem_d[mem_idx] <= mem_dat;
    end
  end

  assign rREGA = mem_a[{rTHR, rRA}];
  assign rREGB = mem_b[{rTHR, rRB}];
  assign reg_d = mem_d[{rTHR, rRD}];

  // ---------------------------------------------------------- load path
  aemb_ldsz #(.DW(DW)) u_ldsz (
    .sel  (rDWBSEL),
    .sext (rSEXT),
    .dat  (dwb_dat_i),
    .q    (rDWBDI)
  );

  always_comb begin
    case (rMXDST)
      MX_RES:  wr_dat = rRESULT;
      MX_LNK:  wr_dat = {rPCLNK, 2'b00};
      default: wr_dat = rDWBDI;
    endcase
  end

  // --------------------------------------------------------- store path
  // A store reading the register being written this cycle sees the new
  // value; link write-backs are not forwarded.
  always_comb begin
    st_src = reg_d;
    if (run_we && (rTHW == rTHR) && (rRW == rRD)) begin
      if (rMXDST == MX_LDM)      st_src = rDWBDI;
      else if (rMXDST == MX_RES) st_src = rRESULT;
    end
  end

  always_comb begin
    st_dat = '0;
    for (int i = 0; i < DW; i++) begin
      case (rOPC)
        SZ_B:    st_dat[i] = st_src[i % 8];
        SZ_H:    st_dat[i] = st_src[i % 16];
        SZ_W:    st_dat[i] = st_src[i];
        default: st_dat[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (grst)      dwb_dat_o <= '0;
    else if (gena) dwb_dat_o <= st_dat;
  end

endmodule

// File: tb/tb_aemb_regf_mt.sv
`timescale 1ns/1ps
module tb_aemb_regf_mt;
  import aemb_pkg::*;

  // ------------------------------------------------ clock / reset block
  logic        gclk = 1'b0;
  logic        grst;
  always #5 gclk = ~gclk;

  logic        gena;
  logic [0:0]  rTHR, rTHW;
  logic [4:0]  rRA, rRB, rRD, rRW;
  logic [1:0]  rMXDST;
  logic [29:0] rPCLNK;
  logic [31:0] rRESULT;
  logic [1:0]  rOPC;
  logic [3:0]  rDWBSEL;
  logic        rSEXT;
  logic [31:0] dwb_dat_i;
  logic [31:0] rREGA, rREGB, rDWBDI, dwb_dat_o;
  logic        clr_busy;
  state_e      state;

  aemb_regf_mt #(.DW(32), .AW(5), .THW(1)) dut (
    .gclk(gclk), .grst(grst), .gena(gena),
    .rTHR(rTHR), .rTHW(rTHW), .rRA(rRA), .rRB(rRB), .rRD(rRD), .rRW(rRW),
    .rMXDST(rMXDST), .rPCLNK(rPCLNK), .rRESULT(rRESULT), .rOPC(rOPC),
    .rDWBSEL(rDWBSEL), .rSEXT(rSEXT), .dwb_dat_i(dwb_dat_i),
    .rREGA(rREGA), .rREGB(rREGB), .rDWBDI(rDWBDI), .dwb_dat_o(dwb_dat_o),
    .clr_busy(clr_busy), .state(state)
  );

  // ---------------------------------------------------------- scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] model [64];
  logic [31:0] last_st;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] d, input logic [3:0] sel, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    case (sel)
      4'h1: begin b = d[7:0];   return sx ? {{24{b[7]}}, b} : {24'h0, b}; end
      4'h2: begin b = d[15:8];  return sx ? {{24{b[7]}}, b} : {24'h0, b}; end
      4'h4: begin b = d[23:16]; return sx ? {{24{b[7]}}, b} : {24'h0, b}; end
      4'h8: begin b = d[31:24]; return sx ? {{24{b[7]}}, b} : {24'h0, b}; end
      4'h3: begin h = d[15:0];  return sx ? {{16{h[15]}}, h} : {16'h0, h}; end
      4'hC: begin h = d[31:16]; return sx ? {{16{h[15]}}, h} : {16'h0, h}; end
      4'hF: return d;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] d, input logic [1:0] opc);
    case (opc)
      2'd0: return {4{d[7:0]}};
      2'd1: return {2{d[15:0]}};
      2'd2: return d;
      default: return 32'h0;
    endcase
  endfunction

  // ------------------------------------------------------- driver tasks
  task automatic idle();
    gena = 1'b1; rMXDST = MX_NOP; rRW = 5'd0; rOPC = 2'd2;
  endtask

  // Inputs are already driven (at a negedge); predict, clock, compare.
  task automatic step();
    logic        wen;
    logic [31:0] wd, ld, src;
    #1;
    ld = ld_model(dwb_dat_i, rDWBSEL, rSEXT);
    chk("ldsz", rDWBDI, ld);
    wen = gena && (rRW != 0) && (rMXDST != 2'd3);
    case (rMXDST)
      2'd0:    wd = rRESULT;
      2'd1:    wd = {rPCLNK, 2'b00};
      default: wd = ld;
    endcase
    src = model[{rTHR, rRD}];
    if (wen && rTHW == rTHR && rRW == rRD) begin
      if (rMXDST == 2'd2)      src = ld;
      else if (rMXDST == 2'd0) src = rRESULT;
    end
    if (gena) last_st = st_model(src, rOPC);
    exp_q.push_back(last_st);
    @(posedge gclk);
    if (wen) model[{rTHW, rRW}] = wd;
    @(negedge gclk);
    chk("q_level", exp_q.size(), 1);
    chk("dwb", dwb_dat_o, exp_q.pop_front());
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (clr_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge gclk);
    end
  endtask

  task automatic sweep(input string tag);
    gena = 1'b0; rMXDST = MX_NOP;
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < 32; r++) begin
        rTHR = t[0:0]; rRA = r[4:0]; rRB = 5'(31 - r);
        #0.1;
        chk(tag, rREGA, model[{rTHR, rRA}]);
        chk(tag, rREGB, model[{rTHR, rRB}]);
      end
    end
    @(negedge gclk);
    gena = 1'b1;
  endtask

  // ---------------------------------------------------------- stimulus
  int n;
  logic [3:0] sel_tab [8];

  initial begin
    sel_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h5};
    grst = 1'b1; gena = 1'b0;
    rTHR = 0; rTHW = 0; rRA = 0; rRB = 0; rRD = 0; rRW = 0;
    rMXDST = MX_NOP; rPCLNK = 0; rRESULT = 0; rOPC = 0;
    rDWBSEL = 4'hF; rSEXT = 0; dwb_dat_i = 0;
    last_st = 32'h0;
    for (int i = 0; i < 64; i++) model[i] = 32'h0;

    repeat (2) @(posedge gclk);
    @(negedge gclk);
    chk("rst_busy", 32'(clr_busy), 32'd1);
    chk("rst_dwb", dwb_dat_o, 32'h0);
    grst = 1'b0; gena = 1'b1;
    count_clear(n);
    chk("clr_len", n, 64);
    chk("run_state", 32'(state), 32'(ST_RUN));
    sweep("clr_zero");

    // thread-banked write
    idle(); rTHW = 0; rRW = 5'd3; rMXDST = MX_RES; rRESULT = 32'hDEADBEEF;
    step();
    idle(); rTHR = 1; rRA = 5'd3; #1;
    chk("t1_r3", rREGA, 32'h0);
    rTHR = 0; #1;
    chk("t0_r3", rREGA, 32'hDEADBEEF);
    @(negedge gclk);

    // R0 is not writable
    idle(); rRW = 5'd0; rMXDST = MX_RES; rRESULT = 32'h12345678;
    step();
    idle(); rTHR = 0; rRA = 0; rRB = 0; #1;
    chk("t0_r0a", rREGA, 32'h0);
    chk("t0_r0b", rREGB, 32'h0);
    rTHR = 1; #1;
    chk("t1_r0a", rREGA, 32'h0);
    @(negedge gclk);

    // load sizer
    dwb_dat_i = 32'h80F07F01;
    rDWBSEL = 4'h8; rSEXT = 1; #1; chk("ld_b3_sx", rDWBDI, 32'hFFFFFF80);
    rDWBSEL = 4'h3; rSEXT = 0; #1; chk("ld_h0", rDWBDI, 32'h00007F01);
    rDWBSEL = 4'h5;            #1; chk("ld_bad", rDWBDI, 32'h0);
    rDWBSEL = 4'hC; rSEXT = 1; #1; chk("ld_h1_sx", rDWBDI, 32'hFFFF80F0);
    rDWBSEL = 4'h1; rSEXT = 1; #1; chk("ld_b0_sx", rDWBDI, 32'h00000001);
    rDWBSEL = 4'hF; rSEXT = 1; #1; chk("ld_w", rDWBDI, 32'h80F07F01);
    rSEXT = 0;
    @(negedge gclk);

    // store sizer
    idle(); rTHW = 0; rTHR = 0; rRW = 5'd5; rMXDST = MX_RES; rRESULT = 32'h000000A5;
    step();
    idle(); rRD = 5'd5; rOPC = 2'd0; step(); chk("st_byte", dwb_dat_o, 32'hA5A5A5A5);
    idle(); rRD = 5'd5; rOPC = 2'd1; step(); chk("st_half", dwb_dat_o, 32'h00A500A5);
    idle(); rRD = 5'd5; rOPC = 2'd3; step(); chk("st_ill", dwb_dat_o, 32'h0);

    // forwarding of a same-cycle load write-back
    idle(); rRW = 5'd5; rMXDST = MX_LDM; rDWBSEL = 4'hF; dwb_dat_i = 32'h11223344;
    rRD = 5'd5; rOPC = 2'd0;
    step(); chk("fwd_ld", dwb_dat_o, 32'h44444444);
    idle(); rRA = 5'd5; #1; chk("r5_ld", rREGA, 32'h11223344);
    @(negedge gclk);
    idle(); rRW = 5'd5; rMXDST = MX_RES; rRESULT = 32'h0000BEEF; rRD = 5'd5; rOPC = 2'd1;
    step(); chk("fwd_res", dwb_dat_o, 32'hBEEFBEEF);

    // link write-back is not forwarded
    idle(); rRW = 5'd7; rMXDST = MX_LNK; rPCLNK = 30'h0ABCDEF1; rRD = 5'd7; rOPC = 2'd2;
    step(); chk("lnk_nofwd", dwb_dat_o, 32'h0);
    idle(); rRA = 5'd7; #1; chk("lnk_rd", rREGA, 32'h2AF37BC4);
    @(negedge gclk);

    // random traffic against the model
    for (int it = 0; it < 80; it++) begin
      rTHW = 1'($urandom_range(0, 1)); rTHR = 1'($urandom_range(0, 1));
      rRW = 5'($urandom_range(0, 31)); rRA = 5'($urandom_range(0, 31));
      rRB = 5'($urandom_range(0, 31));
      rRD = ($urandom_range(0, 2) == 0) ? rRW : 5'($urandom_range(0, 31));
      rMXDST = 2'($urandom_range(0, 3)); rPCLNK = 30'($urandom);
      rRESULT = $urandom; dwb_dat_i = $urandom;
      rDWBSEL = ($urandom_range(0, 7) == 7) ? 4'($urandom_range(0, 15))
                                            : sel_tab[$urandom_range(0, 6)];
      rSEXT = 1'($urandom_range(0, 1)); rOPC = 2'($urandom_range(0, 3));
      gena = ($urandom_range(0, 4) != 0);
      #1;
      chk("rnd_a", rREGA, model[{rTHR, rRA}]);
      chk("rnd_b", rREGB, model[{rTHR, rRB}]);
      step();
    end

    // reset pulsed part-way through a clear
    idle();
    grst = 1'b1; @(posedge gclk); @(negedge gclk); grst = 1'b0;
    last_st = 32'h0;
    chk("rst2_dwb", dwb_dat_o, 32'h0);
    repeat (20) @(negedge gclk);
    chk("mid_busy", 32'(clr_busy), 32'd1);
    grst = 1'b1; @(negedge gclk); grst = 1'b0;
    count_clear(n);
    chk("reclr_len", n, 64);
    for (int i = 0; i < 64; i++) model[i] = 32'h0;
    sweep("reclr_zero");

    // gena low freezes writes and the store register
    idle(); rTHW = 0; rTHR = 0; rRW = 5'd4; rMXDST = MX_RES; rRESULT = 32'h00000055;
    step();
    idle(); rRD = 5'd4; rOPC = 2'd2; step(); chk("st_r4", dwb_dat_o, 32'h00000055);
    idle(); gena = 1'b0; rRW = 5'd4; rMXDST = MX_RES; rRESULT = 32'h00000099;
    rRD = 5'd4; rOPC = 2'd0;
    step(); chk("hold_dwb", dwb_dat_o, 32'h00000055);
    rRA = 5'd4; #1; chk("hold_reg", rREGA, 32'h00000055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
